// File: rtl/apb_stim_pkg.sv
// apb_stim_pkg: shared types and field-width helpers for the APB stimulus master.
// FSM state encoding and the packed command-word width.
package apb_stim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // Command word layout: {write, addr, wdata}
  function automatic int unsigned cmd_w(
    input int unsigned aw,
    input int unsigned dw
  );
    return aw + dw + 1;
  endfunction

endpackage

// File: rtl/apb_stim_fifo.sv
// apb_stim_fifo: synchronous command FIFO with full/empty/count status.
// DEPTH must be a power of two so the pointers wrap naturally.
module apb_stim_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // A full FIFO refuses a push even when a pop frees a slot this cycle
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/apb_stim_master.sv
// apb_stim_master: queued-command APB3 master with one response per transfer.
// Define APB_TIMEOUT_EN to abort transfers stalled for TIMEOUT ACCESS cycles.
module apb_stim_master
  import apb_stim_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [DATA_W-1:0]       cmd_wdata,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_W-1:0]       paddr,
  output logic [DATA_W-1:0]       pwdata,
  input  logic [DATA_W-1:0]       prdata,
  input  logic                    pready,
  input  logic                    pslverr,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  cmd_count
);

  localparam int unsigned CW = cmd_w(ADDR_W, DATA_W);

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_to_q, rsp_to_d;

  logic              full;
  logic              empty;
  logic              pop;
  logic              load;
  logic              to_hit;
  logic [CW-1:0]     fifo_rdata;

  apb_stim_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (cmd_valid),
    .wdata_i ({cmd_write, cmd_addr, cmd_wdata}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cmd_count)
  );

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q <= '0;
    end else if (state_q == SETUP) begin
      tcnt_q <= '0;
    end else if (state_q == ACCESS && !pready) begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end

  // Fires on the TIMEOUT-th stalled ACCESS cycle
  assign to_hit = (state_q == ACCESS) && !pready &&
                  (tcnt_q == TW'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    pop         = 1'b0;
    load        = 1'b0;
    unique case (state_q)
      IDLE: load = !empty;
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready || to_hit) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (pwrite_q || to_hit) ? '0 : prdata;
          rsp_err_d   = pslverr || to_hit;
          rsp_to_d    = to_hit;
          load        = !empty;
          if (empty) begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Back-to-back issue keeps psel high and restarts at SETUP
    if (load) begin
      pop       = 1'b1;
      state_d   = SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      {pwrite_d, paddr_d, pwdata_d} = fifo_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign cmd_ready   = !full;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_to_q;
  assign busy        = (state_q != IDLE) || !empty;

endmodule
